// File: rtl/load_store_unit_pkg.sv
// ============================================================================
// Module   : load_store_unit_pkg
// Purpose  : Shared definitions for the load/store unit: access size codes,
//            FSM state encoding and byte-enable constants.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package load_store_unit_pkg;

  // Access size codes carried on ex_size (2'b11 is handled as a word)
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Controller states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } lsu_state_e;

  // Byte-enable patterns, bit i = byte lane i
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/load_store_unit_align.sv
// ============================================================================
// Module   : lsu_align
// Purpose  : Combinational byte-enable generation and lane replication of
//            right-aligned store data for the load/store unit.
// Ports    : size_i     - access size code
//            addr_lo_i  - byte address bits [1:0]
//            wdata_i    - right-aligned store data
//            be_o       - byte enables, bit i = lane i
//            wdata_o    - store data replicated across the active lanes
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);

  always_comb begin
    be_o    = BE_WORD;
    wdata_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o    = BE_BYTE0 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        // addr[0] is ignored: a halfword always occupies an aligned lane pair
        be_o    = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        // SZ_WORD and the reserved code both behave as a full word
        be_o    = BE_WORD;
        wdata_o = wdata_i;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Purpose  : Memory-stage load/store unit. Accepts one memory instruction at
//            a time, drives the data-memory request/ack bus and stalls the
//            pipeline until the access is acknowledged. Loads return the raw
//            word plus the halfword-select bit to the next stage.
// Ports    : clk_i, rst_ni              - clock, async active-low reset
//            ex_*_i                     - instruction from EX/MEM
//            flush_i                    - cancel writeback of current access
//            stall_o                    - freeze upstream pipeline registers
//            mem_*_o / mem_ack_i,
//            mem_rdata_i                - data-memory request/ack bus
//            wb_valid_o, wb_data_o,
//            wb_half_sel_o              - load result toward writeback
//            misalign_o                 - misaligned-access pulse (only with
//                                         LSU_MISALIGN_TRAP_EN defined)
// Config   : LSU_MISALIGN_TRAP_EN - reject misaligned half/word accesses
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ex_valid_i,
  input  logic              ex_we_i,
  input  logic [1:0]        ex_size_i,
  input  logic [ADDR_W-1:0] ex_addr_i,
  input  logic [31:0]       ex_wdata_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              wb_valid_o,
  output logic [31:0]       wb_data_o,
  output logic              wb_half_sel_o
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic              misalign_o
`endif
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              kill_q, kill_d;
  logic              wb_valid_q, wb_valid_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              wb_half_q, wb_half_d;

  logic              req_active;
  logic              misaligned;
  logic [3:0]        align_be;
  logic [31:0]       align_wdata;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  // Half needs addr[0]==0; word (and the reserved size code) needs addr[1:0]==0
  assign misaligned = ((ex_size_i == SZ_HALF) && ex_addr_i[0]) ||
                      (ex_size_i[1] && (ex_addr_i[1:0] != 2'b00));
  assign misalign_d = (state_q == ST_IDLE) && ex_valid_i && !flush_i && misaligned;
  assign misalign_o = misalign_q;
`else
  assign misaligned = 1'b0;
`endif

  lsu_align u_align (
    .size_i    (size_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .be_o      (align_be),
    .wdata_o   (align_wdata)
  );

  assign req_active = (state_q == ST_REQ);

  // Bus outputs are gated by the request so they read zero while idle and
  // drop together with mem_req the instant reset clears the state register.
  assign mem_req_o   = req_active;
  assign mem_we_o    = req_active & we_q;
  assign mem_addr_o  = req_active ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be_o    = req_active ? align_be : 4'b0000;
  assign mem_wdata_o = req_active ? align_wdata : 32'h0;

  // Release the pipeline in the ack cycle so upstream advances on that edge;
  // a rejected misaligned access never holds the pipeline.
  assign stall_o = ex_valid_i &
                   !(req_active && mem_ack_i) &
                   !((state_q == ST_IDLE) && misaligned);

  assign wb_valid_o    = wb_valid_q;
  assign wb_data_o     = wb_data_q;
  assign wb_half_sel_o = wb_half_q;

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    kill_d     = kill_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_half_d  = wb_half_q;
    case (state_q)
      ST_IDLE: begin
        kill_d = 1'b0;
        if (ex_valid_i && !flush_i && !misaligned) begin
          state_d = ST_REQ;
          we_d    = ex_we_i;
          size_d  = ex_size_i;
          addr_d  = ex_addr_i;
          wdata_d = ex_wdata_i;
        end
      end
      ST_REQ: begin
        if (flush_i) begin
          kill_d = 1'b1;
        end
        if (mem_ack_i) begin
          state_d = ST_IDLE;
          kill_d  = 1'b0;
          if (!we_q) begin
            wb_data_d  = mem_rdata_i;
            wb_half_d  = addr_q[1];
            // A flush arriving in the ack cycle itself also cancels writeback
            wb_valid_d = !(kill_q || flush_i);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      size_q     <= SZ_BYTE;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      kill_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= 32'h0;
      wb_half_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      kill_q     <= kill_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_half_q  <= wb_half_d;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit of the 5-stage MIPS pipeline. It accepts one memory instruction at a time from EX/MEM, drives the data-memory request/ack bus with byte enables and lane-replicated store data, and stalls the pipeline until memory acknowledges. For loads it registers the raw 32-bit word and the halfword-select bit. The downstream halfword select/sign-extend stage consumes both to produce the writeback value.

## Interface
- ADDR_W, 32, byte-address width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  memory instruction present in EX/MEM
- ex_we  in  1  1 = store, 0 = load
- ex_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- ex_addr  in  ADDR_W  byte address
- ex_wdata  in  32  store data, right-aligned
- flush  in  1  cancel the current instruction's writeback
- stall  out  1  freeze PC/IF/ID/EX/EX-MEM registers
- mem_req  out  1  request valid to data memory
- mem_we  out  1  request is a write
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- mem_be  out  4  byte enables, bit i = byte lane i
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completed request this cycle
- mem_rdata  in  32  read data, valid when mem_ack and !mem_we
- wb_valid  out  1  one-cycle pulse: load data valid
- wb_data  out  32  raw memory word for the halfword stage
- wb_half_sel  out  1  addr[1] of the load; 1 = upper halfword
- misalign  out  1  only with LSU_MISALIGN_TRAP_EN; one-cycle pulse

## Operation
- FSM states are IDLE and REQ.
- IDLE with ex_valid and no flush: latch we/size/addr/wdata and go to REQ.
- REQ: mem_req=1, and mem_* outputs come from the latched request and stay stable until mem_ack. On mem_ack, go to IDLE.
- stall = ex_valid & !(state==REQ & mem_ack). This is combinational. Upstream holds ex_* while stall=1 and advances in the ack cycle.
- Load ack: register wb_data<=mem_rdata and wb_half_sel<=latched addr[1]; wb_valid=1 next cycle for exactly one cycle.
- Store ack produces no wb_valid.
- Byte: be=1<<addr[1:0], wdata={4{wdata[7:0]}}. Half: be=addr[1]?1100:0011, wdata={2{wdata[15:0]}}. Word: be=1111, wdata unchanged.
- Loads drive be by the same rule. Memory ignores be on reads.
- flush in IDLE: no accept. flush in REQ: set kill. The bus transaction completes normally, and kill suppresses wb_valid. kill clears on return to IDLE.
- Reset mid-transaction: FSM to IDLE immediately. mem_req drops asynchronously, and no wb_valid is issued.

## Timing
- Reset values: stall follows ex_valid; every other output is 0, including mem_* buses, wb_*, and misalign.
- Load latency: accept at cycle 0, mem_req from cycle 1, ack at cycle 1+N, wb_valid at cycle 2+N. Minimum is 2 cycles (N=0).
- Throughput: one access per 2+N cycles. There is no back-to-back issue.
- mem_ack outside REQ is ignored.
- wb_data/wb_half_sel hold their value until the next load ack.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Half with addr[0]=1, or word with addr[1:0]!=0, is not issued. State stays IDLE.
  - misalign pulses 1 in the cycle after ex_valid is seen.
  - stall=0 for that instruction.
- LSU_MISALIGN_TRAP_EN undefined:
  - No check; the misalign port is absent.
  - Half ignores addr[0]; word ignores addr[1:0].

## Structure
- The shared package holds:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state encodings ST_IDLE/ST_REQ;
  - the byte-enable constants.
- One sub-module, lsu_align: combinational generation of be and replicated wdata from size, addr[1:0] and wdata.

## Test plan
- Load word at addr 0x100 with ack after 3 cycles, rdata=0xDEADBEEF:
  - mem_addr=0x100, be=1111;
  - stall high for 4 cycles;
  - wb_valid pulse with wb_data=0xDEADBEEF, wb_half_sel=0.
- Store half at addr 0x0A, wdata=0x1234ABCD, ack at N=0: mem_we=1, be=1100, mem_wdata=0xABCDABCD, no wb_valid.
- Store byte at addr 0x07, wdata=0x000000A5: mem_addr=0x04, be=1000, mem_wdata=0xA5A5A5A5.
- Load with flush asserted in REQ: request completes on ack, wb_valid stays 0, FSM returns to IDLE.
- rst_n low during REQ: mem_req drops immediately, outputs 0, and the next ex_valid is accepted normally after release.
- With LSU_MISALIGN_TRAP_EN, load word at 0x102: no mem_req, misalign=1 for one cycle, stall=0.
